// File: rtl/mdu_pkg.sv
// Shared encodings and helpers for the MDU issue controller.
package mdu_pkg;

    localparam int unsigned OP_W   = 3;
    localparam int unsigned DATA_W = 32;

    // EX-side MDU operation encodings
    typedef enum logic [OP_W-1:0] {
        MDU_NONE  = 3'd0,
        MDU_MULT  = 3'd1,
        MDU_MULTU = 3'd2,
        MDU_DIV   = 3'd3,
        MDU_DIVU  = 3'd4,
        MDU_MTLO  = 3'd5,
        MDU_MTHI  = 3'd6,
        MDU_MF    = 3'd7
    } mdu_op_e;

    // Issue FSM states
    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ISSUE     = 2'd1,
        WAIT_BUSY = 2'd2,
        RUN       = 2'd3
    } mdu_state_e;

    // Captured transaction presented to the MDU during ISSUE
    typedef struct packed {
        logic [OP_W-1:0]   op;
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b;
    } mdu_req_t;

    // Multiply/divide ops that raise MDU Busy and must be watched
    function automatic logic is_long_op(input logic [OP_W-1:0] op);
        return (op >= OP_W'(MDU_MULT)) && (op <= OP_W'(MDU_DIVU));
    endfunction

    // Ops that go through the issue FSM (everything except none and mf)
    function automatic logic is_issue_op(input logic [OP_W-1:0] op);
        return (op != OP_W'(MDU_NONE)) && (op != OP_W'(MDU_MF));
    endfunction

endpackage

// File: rtl/mdu_issue_ctrl.sv
// Pipeline-side MDU initiator: issues one Start transaction per MDU op,
// tracks Busy with a watchdog, stalls EX on hazards and returns mf data.
module mdu_issue_ctrl
    import mdu_pkg::*;
#(
    parameter int unsigned BUSY_WAIT_MAX = 2,
    parameter int unsigned RUN_MAX       = 16,
    parameter int unsigned CNT_W         = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ex_valid,
    input  logic [OP_W-1:0]   ex_op,
    input  logic              ex_mf_sel,
    input  logic [DATA_W-1:0] ex_a,
    input  logic [DATA_W-1:0] ex_b,
    input  logic              flush,
    input  logic              mdu_busy,
    input  logic [DATA_W-1:0] mdu_out,
    output logic              mdu_start,
    output logic [OP_W-1:0]   mdu_op,
    output logic [DATA_W-1:0] mdu_a,
    output logic [DATA_W-1:0] mdu_b,
    output logic              mdu_sel,
    output logic              stall,
    output logic [DATA_W-1:0] mf_data,
    output logic              mf_valid,
    output logic              timeout_err
);

    mdu_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
    mdu_req_t         req_q;
    logic             req, accept, wdog_expire;

    assign req     = ex_valid && (ex_op != OP_W'(MDU_NONE));
    assign accept  = (state_q == IDLE) && req && is_issue_op(ex_op) && !flush;
    assign cnt_inc = cnt_q + CNT_W'(1);

    // State, watchdog counter, captured transaction and sticky error
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            req_q       <= '0;
            timeout_err <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                req_q.op <= ex_op;
                req_q.a  <= ex_a;
                req_q.b  <= ex_b;
            end
            if (wdog_expire) begin
                timeout_err <= 1'b1;
            end
        end
    end

    // Next-state and watchdog sequencing
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        wdog_expire = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                if (flush) begin
                    state_d = IDLE;
                end else if (is_long_op(req_q.op)) begin
                    state_d = WAIT_BUSY;
                    cnt_d   = '0;
                end else begin
                    state_d = IDLE;
                end
            end
            WAIT_BUSY: begin
                if (mdu_busy) begin
                    state_d = RUN;
                    cnt_d   = '0;
                end else if (cnt_inc == CNT_W'(BUSY_WAIT_MAX)) begin
                    wdog_expire = 1'b1;
                    state_d     = IDLE;
                    cnt_d       = '0;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            RUN: begin
                if (!mdu_busy) begin
                    state_d = IDLE;
                end else if (cnt_inc == CNT_W'(RUN_MAX)) begin
                    wdog_expire = 1'b1;
                    state_d     = IDLE;
                    cnt_d       = '0;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // MDU drive, pipeline stall and mf return path
    always_comb begin
        mdu_start = 1'b0;
        mdu_op    = '0;
        mdu_a     = '0;
        mdu_b     = '0;
        mdu_sel   = ex_mf_sel;
        stall     = req && (state_q != IDLE);
        mf_data   = mdu_out;
        mf_valid  = ex_valid && (ex_op == OP_W'(MDU_MF)) && (state_q == IDLE) && !flush;
        if (state_q == ISSUE) begin
            mdu_a = req_q.a;
            mdu_b = req_q.b;
            // A flush in ISSUE cancels the start before the MDU sees it
            if (!flush) begin
                mdu_start = 1'b1;
                mdu_op    = req_q.op;
            end
        end
    end

endmodule

// File: tb/tb_mdu_issue_ctrl.sv
// Directed table-driven bench for mdu_issue_ctrl with a small HI/LO model.
module tb_mdu_issue_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        ex_valid;
    logic [2:0]  ex_op;
    logic        ex_mf_sel;
    logic [31:0] ex_a, ex_b;
    logic        flush;
    logic        mdu_busy;
    logic [31:0] mdu_out;
    logic        mdu_start;
    logic [2:0]  mdu_op;
    logic [31:0] mdu_a, mdu_b;
    logic        mdu_sel;
    logic        stall;
    logic [31:0] mf_data;
    logic        mf_valid;
    logic        timeout_err;

    int n_vec  = 0;
    int n_miss = 0;

    mdu_issue_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .ex_valid    (ex_valid),
        .ex_op       (ex_op),
        .ex_mf_sel   (ex_mf_sel),
        .ex_a        (ex_a),
        .ex_b        (ex_b),
        .flush       (flush),
        .mdu_busy    (mdu_busy),
        .mdu_out     (mdu_out),
        .mdu_start   (mdu_start),
        .mdu_op      (mdu_op),
        .mdu_a       (mdu_a),
        .mdu_b       (mdu_b),
        .mdu_sel     (mdu_sel),
        .stall       (stall),
        .mf_data     (mf_data),
        .mf_valid    (mf_valid),
        .timeout_err (timeout_err)
    );

    always #5 clk = ~clk;

    // Behavioural HI/LO registers updated by each Start the DUT issues
    logic [31:0] hi_m = '0;
    logic [31:0] lo_m = '0;

    function automatic logic [63:0] sx(input logic [31:0] x);
        return {{32{x[31]}}, x};
    endfunction

    always @(posedge clk) begin
        if (mdu_start) begin
            case (mdu_op)
                3'd1: {hi_m, lo_m} <= sx(mdu_a) * sx(mdu_b);
                3'd2: {hi_m, lo_m} <= {32'd0, mdu_a} * {32'd0, mdu_b};
                3'd3: begin
                    lo_m <= $signed(mdu_a) / $signed(mdu_b);
                    hi_m <= $signed(mdu_a) % $signed(mdu_b);
                end
                3'd4: begin
                    lo_m <= mdu_a / mdu_b;
                    hi_m <= mdu_a % mdu_b;
                end
                3'd5: lo_m <= mdu_a;
                3'd6: hi_m <= mdu_a;
                default: ;
            endcase
        end
    end

    assign mdu_out = mdu_sel ? hi_m : lo_m;

    typedef struct packed {
        logic        v;
        logic [2:0]  op;
        logic        sel;
        logic [31:0] a;
        logic [31:0] b;
        logic        fl;
        logic        busy;
    } in_t;

    typedef struct packed {
        logic        start;
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic        stall;
        logic        mfv;
        logic [31:0] mfd;
        logic        terr;
    } out_t;

    typedef struct {
        in_t  i;
        out_t e;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic v, input logic [2:0] op, input logic sel,
                                input logic [31:0] a, input logic [31:0] b,
                                input logic fl, input logic busy,
                                input logic st, input logic [2:0] eop,
                                input logic [31:0] ea, input logic [31:0] eb,
                                input logic est, input logic mfv,
                                input logic [31:0] mfd, input logic terr);
        vec_t t;
        t.i = '{v: v, op: op, sel: sel, a: a, b: b, fl: fl, busy: busy};
        t.e = '{start: st, op: eop, a: ea, b: eb, stall: est, mfv: mfv, mfd: mfd, terr: terr};
        return t;
    endfunction

    task automatic add(input logic v, input logic [2:0] op, input logic sel,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic fl, input logic busy,
                       input logic st, input logic [2:0] eop,
                       input logic [31:0] ea, input logic [31:0] eb,
                       input logic est, input logic mfv,
                       input logic [31:0] mfd, input logic terr);
        tbl.push_back(mk(v, op, sel, a, b, fl, busy, st, eop, ea, eb, est, mfv, mfd, terr));
    endtask

    task automatic set_in(input in_t i);
        ex_valid  = i.v;
        ex_op     = i.op;
        ex_mf_sel = i.sel;
        ex_a      = i.a;
        ex_b      = i.b;
        flush     = i.fl;
        mdu_busy  = i.busy;
    endtask

    // mf_data is only meaningful (and only compared) when mf_valid is expected
    task automatic check_out(input vec_t t, input string name);
        logic bad;
        n_vec++;
        bad = (mdu_start !== t.e.start) || (mdu_op !== t.e.op) ||
              (mdu_a !== t.e.a) || (mdu_b !== t.e.b) ||
              (stall !== t.e.stall) || (mf_valid !== t.e.mfv) ||
              (timeout_err !== t.e.terr) || (mdu_sel !== t.i.sel) ||
              (t.e.mfv && (mf_data !== t.e.mfd));
        if (bad) begin
            n_miss++;
            $display("FAIL %s: got start=%b op=%0d a=%h b=%h stall=%b mfv=%b mfd=%h terr=%b sel=%b | exp start=%b op=%0d a=%h b=%h stall=%b mfv=%b mfd=%h terr=%b sel=%b",
                     name, mdu_start, mdu_op, mdu_a, mdu_b, stall, mf_valid, mf_data, timeout_err, mdu_sel,
                     t.e.start, t.e.op, t.e.a, t.e.b, t.e.stall, t.e.mfv, t.e.mfd, t.e.terr, t.i.sel);
        end
    endtask

    // One cycle: drive just after posedge, check at negedge
    task automatic run_vec(input vec_t t, input string name);
        set_in(t.i);
        @(negedge clk);
        check_out(t, name);
        @(posedge clk);
        #1;
    endtask

    task automatic step(input string name,
                        input logic v, input logic [2:0] op, input logic sel,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic fl, input logic busy,
                        input logic st, input logic [2:0] eop,
                        input logic [31:0] ea, input logic [31:0] eb,
                        input logic est, input logic mfv,
                        input logic [31:0] mfd, input logic terr);
        run_vec(mk(v, op, sel, a, b, fl, busy, st, eop, ea, eb, est, mfv, mfd, terr), name);
    endtask

    initial begin
        rst = 1'b1;
        set_in('0);

        // mult 7 * -3, mf held in EX through ISSUE/WAIT_BUSY/RUN
        add(0,0,0,0,0,0,0,            0,0,0,0,0,0,0,0);
        add(1,1,0,7,32'hFFFFFFFD,0,0, 0,0,0,0,0,0,0,0);
        add(1,7,0,0,0,0,0,            1,1,7,32'hFFFFFFFD,1,0,0,0);
        add(1,7,0,0,0,0,1,            0,0,0,0,1,0,0,0);
        for (int k = 0; k < 4; k++) add(1,7,0,0,0,0,1, 0,0,0,0,1,0,0,0);
        add(1,7,0,0,0,0,0,            0,0,0,0,1,0,0,0);
        add(1,7,0,0,0,0,0,            0,0,0,0,0,1,32'hFFFFFFEB,0);
        add(1,7,1,0,0,0,0,            0,0,0,0,0,1,32'hFFFFFFFF,0);
        // div 100 / 7 then mflo / mfhi
        add(1,3,0,100,7,0,0,          0,0,0,0,0,0,0,0);
        add(1,7,0,0,0,0,0,            1,3,100,7,1,0,0,0);
        add(1,7,0,0,0,0,1,            0,0,0,0,1,0,0,0);
        add(1,7,0,0,0,0,1,            0,0,0,0,1,0,0,0);
        add(1,7,0,0,0,0,0,            0,0,0,0,1,0,0,0);
        add(1,7,0,0,0,0,0,            0,0,0,0,0,1,14,0);
        add(1,7,1,0,0,0,0,            0,0,0,0,0,1,2,0);
        // mtlo then mflo back-to-back
        add(1,5,0,32'h1234,0,0,0,     0,0,0,0,0,0,0,0);
        add(1,7,0,0,0,0,0,            1,5,32'h1234,0,1,0,0,0);
        add(1,7,0,0,0,0,0,            0,0,0,0,0,1,32'h1234,0);
        // flush in ISSUE cancels a mult; HI untouched
        add(1,1,0,5,6,0,0,            0,0,0,0,0,0,0,0);
        add(0,0,0,0,0,1,0,            0,0,5,6,0,0,0,0);
        add(1,7,1,0,0,0,0,            0,0,0,0,0,1,2,0);
        // flush blocks mf_valid and acceptance in IDLE
        add(1,7,0,0,0,1,0,            0,0,0,0,0,0,0,0);
        add(1,1,0,5,6,1,0,            0,0,0,0,0,0,0,0);
        add(0,0,0,0,0,0,0,            0,0,0,0,0,0,0,0);
        // mthi back-to-back: second accepted on first IDLE cycle
        add(1,6,0,32'hCAFE,0,0,0,     0,0,0,0,0,0,0,0);
        add(1,6,0,32'hBEEF,0,0,0,     1,6,32'hCAFE,0,1,0,0,0);
        add(1,6,0,32'hBEEF,0,0,0,     0,0,0,0,0,0,0,0);
        add(1,7,1,0,0,0,0,            1,6,32'hBEEF,0,1,0,0,0);
        add(1,7,1,0,0,0,0,            0,0,0,0,0,1,32'hBEEF,0);

        // Reset state
        #3;
        check_out(mk(0,0,0,0,0,0,0, 0,0,0,0,0,0,0,0), "reset");
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        foreach (tbl[n]) run_vec(tbl[n], $sformatf("vec%0d", n));

        // Watchdog: divu 9/2 with Busy never rising
        step("wb_acc",   1,4,0,9,2,0,0, 0,0,0,0,0,0,0,0);
        step("wb_iss",   1,7,0,0,0,0,0, 1,4,9,2,1,0,0,0);
        step("wb_w1",    1,7,0,0,0,0,0, 0,0,0,0,1,0,0,0);
        step("wb_w2",    1,7,0,0,0,0,0, 0,0,0,0,1,0,0,0);
        step("wb_err",   1,7,0,0,0,0,0, 0,0,0,0,0,1,4,1);
        step("wb_stky",  0,0,0,0,0,0,0, 0,0,0,0,0,0,0,1);
        step("stky_acc", 1,5,0,77,0,0,0, 0,0,0,0,0,0,0,1);
        step("stky_iss", 0,0,0,0,0,0,0, 1,5,77,0,0,0,0,1);
        step("stky_end", 0,0,0,0,0,0,0, 0,0,0,0,0,0,0,1);

        // Async reset mid-RUN clears error and stall immediately
        step("rr_acc",   1,1,0,3,4,0,0, 0,0,0,0,0,0,0,1);
        step("rr_iss",   1,7,0,0,0,0,0, 1,1,3,4,1,0,0,1);
        step("rr_wait",  1,7,0,0,0,0,1, 0,0,0,0,1,0,0,1);
        step("rr_run1",  1,7,0,0,0,0,1, 0,0,0,0,1,0,0,1);
        step("rr_run2",  1,7,0,0,0,0,1, 0,0,0,0,1,0,0,1);
        set_in(mk(1,7,0,0,0,0,1, 0,0,0,0,0,0,0,0).i);
        #2;
        rst = 1'b1;
        #1;
        check_out(mk(1,7,0,0,0,0,1, 0,0,0,0,0,1,12,0), "rr_async");
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Watchdog: divu 20/3 with Busy stuck high for RUN_MAX cycles
        step("rt_acc",   1,4,0,20,3,0,0, 0,0,0,0,0,0,0,0);
        step("rt_iss",   1,7,0,0,0,0,1,  1,4,20,3,1,0,0,0);
        step("rt_wait",  1,7,0,0,0,0,1,  0,0,0,0,1,0,0,0);
        for (int k = 1; k <= 16; k++)
            step($sformatf("rt_run%0d", k), 1,7,0,0,0,0,1, 0,0,0,0,1,0,0,0);
        step("rt_err",   1,7,0,0,0,0,1,  0,0,0,0,0,1,6,1);

        // Flush during WAIT_BUSY does not cancel a committed multu
        step("fw_acc",   1,2,0,32'hFFFFFFFF,2,0,0, 0,0,0,0,0,0,0,1);
        step("fw_iss",   1,7,0,0,0,0,0, 1,2,32'hFFFFFFFF,2,1,0,0,1);
        step("fw_wait",  1,7,0,0,0,1,1, 0,0,0,0,1,0,0,1);
        step("fw_run",   1,7,0,0,0,0,1, 0,0,0,0,1,0,0,1);
        step("fw_done",  1,7,0,0,0,0,0, 0,0,0,0,1,0,0,1);
        step("fw_mfhi",  1,7,1,0,0,0,0, 0,0,0,0,0,1,1,1);

        // Async reset during ISSUE drops Start at once
        step("ri_acc",   1,3,0,50,5,0,0, 0,0,0,0,0,0,0,1);
        set_in(mk(1,7,0,0,0,0,0, 0,0,0,0,0,0,0,0).i);
        #1;
        check_out(mk(1,7,0,0,0,0,0, 1,3,50,5,1,0,0,1), "ri_iss");
        #2;
        rst = 1'b1;
        #1;
        check_out(mk(1,7,0,0,0,0,0, 0,0,0,0,0,1,32'hFFFFFFFE,0), "ri_async");
        @(posedge clk);
        #1;
        rst = 1'b0;
        step("ri_idle",  0,0,0,0,0,0,0, 0,0,0,0,0,0,0,0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
